// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_pkg                                                       |
// | Purpose  : Shared definitions for the ALU command driver: data width,    |
// |            ALU select codes and the driver FSM state type.               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package alu_pkg;

   localparam int DATA_W = 32;

   localparam logic [2:0] SEL_ADD  = 3'b000;
   localparam logic [2:0] SEL_AND  = 3'b001;
   localparam logic [2:0] SEL_OR   = 3'b010;
   localparam logic [2:0] SEL_MUL  = 3'b011;
   localparam logic [2:0] SEL_SUB  = 3'b100;
   localparam logic [2:0] SEL_SLT  = 3'b101;
   // Idle select driven to the ALU out of reset; the ALU yields R=0, Z=1.
   localparam logic [2:0] SEL_ZERO = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_golden.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_golden                                                    |
// | Purpose  : Combinational reference model of the 32-bit ALU function.     |
// | Ports    : a, b   operands                                               |
// |            sel    op select (add/and/or/mul/sub/slt, 110/111 -> zero)    |
// |            r      result (mul keeps low word, sub wraps, slt unsigned)   |
// |            z      zero flag (r == 0)                                     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module alu_golden
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [2:0]        sel,
   output logic [DATA_W-1:0] r,
   output logic              z
);

   always_comb begin
      r = '0;
      case (sel)
         SEL_ADD: r = a + b;
         SEL_AND: r = a & b;
         SEL_OR:  r = a | b;
         SEL_MUL: r = a * b;
         SEL_SUB: r = a - b;
         SEL_SLT: r = {{(DATA_W-1){1'b0}}, (a < b)};
         default: r = '0;
      endcase
   end

   assign z = (r == '0);

endmodule : alu_golden
`default_nettype wire

// File: rtl/alu_cmd_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_cmd_driver                                                |
// | Purpose  : Initiator for the registered 32-bit ALU. Accepts one tagged   |
// |            command, drives the ALU, waits out its result/flag latency,   |
// |            captures R/Z and returns them on a valid/ready response.      |
// | Ports    : CLK, RST_N            clock, async active-low reset           |
// |            cmd_valid/cmd_ready   command handshake                       |
// |            cmd_a/b/sel/tag       command payload                         |
// |            alu_a/b/sel           operands/select to the ALU              |
// |            alu_r, alu_zflag      ALU result and zero flag                |
// |            rsp_valid/rsp_ready   response handshake                      |
// |            rsp_r/z/tag/err       response payload                        |
// |            busy, ops_done        status, completed-response counter      |
// | Option   : ALU_CMD_DRIVER_CHECK_EN builds a local ALU model and flags a  |
// |            mismatch on rsp_err; otherwise rsp_err is tied low.           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module alu_cmd_driver
   import alu_pkg::*;
#(
   parameter int ALU_LAT = 2,
   parameter int TAG_W   = 4,
   parameter int CNT_W   = 16
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic [2:0]        cmd_sel,
   input  logic [TAG_W-1:0]  cmd_tag,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_sel,
   input  logic [DATA_W-1:0] alu_r,
   input  logic              alu_zflag,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_r,
   output logic              rsp_z,
   output logic [TAG_W-1:0]  rsp_tag,
   output logic              rsp_err,
   output logic              busy,
   output logic [CNT_W-1:0]  ops_done
);

   localparam int c_WAIT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
   localparam logic [c_WAIT_W-1:0] c_WAIT_LOAD = c_WAIT_W'(ALU_LAT);

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_accept;
   logic                w_capture;
   logic                w_handoff;

   logic [DATA_W-1:0]   r_alu_a;
   logic [DATA_W-1:0]   r_alu_b;
   logic [2:0]          r_alu_sel;
   logic [TAG_W-1:0]    r_tag;
   logic [c_WAIT_W-1:0] r_wait;
   logic                r_rsp_valid;
   logic [DATA_W-1:0]   r_rsp_r;
   logic                r_rsp_z;
   logic [TAG_W-1:0]    r_rsp_tag;
   logic [CNT_W-1:0]    r_ops_done;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      w_handoff   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (cmd_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            // Counter was loaded with ALU_LAT at accept, so it reaches zero
            // on the edge after the ALU's flag register has settled.
            if (r_wait == '0) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               w_handoff   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_sel   <= SEL_ZERO;
         r_tag       <= '0;
         r_wait      <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_r     <= '0;
         r_rsp_z     <= 1'b0;
         r_rsp_tag   <= '0;
         r_ops_done  <= '0;
      end else begin
         // Operands are only rewritten on accept, so they stay on the ALU
         // bus between operations.
         if (w_accept) begin
            r_alu_a   <= cmd_a;
            r_alu_b   <= cmd_b;
            r_alu_sel <= cmd_sel;
            r_tag     <= cmd_tag;
            r_wait    <= c_WAIT_LOAD;
         end else if ((r_state == ST_EXEC) && (r_wait != '0)) begin
            r_wait <= r_wait - c_WAIT_W'(1);
         end

         if (w_capture) begin
            r_rsp_valid <= 1'b1;
            r_rsp_r     <= alu_r;
            r_rsp_z     <= alu_zflag;
            r_rsp_tag   <= r_tag;
         end

         if (w_handoff) begin
            r_rsp_valid <= 1'b0;
            r_ops_done  <= r_ops_done + CNT_W'(1);
         end
      end
   end

   // ------------------------------------------------------ result check
`ifdef ALU_CMD_DRIVER_CHECK_EN
   logic [DATA_W-1:0] w_gold_r;
   logic              w_gold_z;
   logic              r_rsp_err;

   alu_golden u_alu_golden (
      .a   (r_alu_a),
      .b   (r_alu_b),
      .sel (r_alu_sel),
      .r   (w_gold_r),
      .z   (w_gold_z)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_rsp_err <= 1'b0;
      end else if (w_capture) begin
         r_rsp_err <= (w_gold_r != alu_r) || (w_gold_z != alu_zflag);
      end
   end

   assign rsp_err = r_rsp_err;
`else
   assign rsp_err = 1'b0;
`endif

   // ------------------------------------------------------------ outputs
   assign cmd_ready = (r_state == ST_IDLE);
   assign busy      = (r_state != ST_IDLE);
   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_sel   = r_alu_sel;
   assign rsp_valid = r_rsp_valid;
   assign rsp_r     = r_rsp_r;
   assign rsp_z     = r_rsp_z;
   assign rsp_tag   = r_rsp_tag;
   assign ops_done  = r_ops_done;

endmodule : alu_cmd_driver
`default_nettype wire
